// File: rtl/soc_sysid_pkg.sv
// Shared types and constants for the system-ID / timestamp checker.
package soc_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ID_CMD  = 3'd1,
        ST_ID_WAIT = 3'd2,
        ST_TS_CMD  = 3'd3,
        ST_TS_WAIT = 3'd4,
        ST_CHECK   = 3'd5,
        ST_FINISH  = 3'd6
    } sysid_state_e;

    // Word addresses on the Avalon-MM slave
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/soc_sysid_checker.sv
// Reads the system ID word and the timestamp word over Avalon-MM, one read
// at a time, and compares them against the expected values.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start
// ID_CMD     | read of address 0 presented, waiting for waitrequest low
// ID_WAIT    | read accepted, waiting for readdatavalid (ID word)
// TS_CMD     | read of address 1 presented, waiting for waitrequest low
// TS_WAIT    | read accepted, waiting for readdatavalid (timestamp word)
// CHECK      | compare captured words, latch pass
// FINISH     | one-cycle done pulse, start ignored
//
// The timeout counter is loaded at start and reloaded on each capture, so it
// bounds a whole read (command + data phase). It saturates at zero; a cycle
// that sees the awaited condition is never treated as a timeout.
module soc_sysid_checker
    import soc_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS = 32'h0000_0000,
    parameter bit          CHECK_TS    = 1'b1,
    parameter int          TIMEOUT     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        err_timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT);

    sysid_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pass_q, pass_d;
    logic          err_q, err_d;
    logic [31:0]   id_q, id_d;
    logic [31:0]   ts_q, ts_d;
    logic [CW-1:0] cnt_dec;

    assign cnt_dec = (cnt_q != '0) ? (cnt_q - CW'(1)) : '0;

    // State and result registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            err_q   <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
        end
    end

    // Next-state, timeout counter and capture logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        err_d   = err_q;
        id_d    = id_q;
        ts_d    = ts_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ID_CMD;
                    cnt_d   = CNT_LOAD;
                    pass_d  = 1'b0;
                    err_d   = 1'b0;
                    id_d    = '0;
                    ts_d    = '0;
                end
            end
            ST_ID_CMD, ST_TS_CMD: begin
                cnt_d = cnt_dec;
                if (!avm_waitrequest) begin
                    state_d = (state_q == ST_ID_CMD) ? ST_ID_WAIT : ST_TS_WAIT;
                end else if (cnt_q == '0) begin
                    state_d = ST_FINISH;
                    err_d   = 1'b1;
                    pass_d  = 1'b0;
                end
            end
            ST_ID_WAIT, ST_TS_WAIT: begin
                cnt_d = cnt_dec;
                if (avm_readdatavalid) begin
                    cnt_d = CNT_LOAD;
                    if (state_q == ST_ID_WAIT) begin
                        id_d    = avm_readdata;
                        state_d = ST_TS_CMD;
                    end else begin
                        ts_d    = avm_readdata;
                        state_d = ST_CHECK;
                    end
                end else if (cnt_q == '0) begin
                    state_d = ST_FINISH;
                    err_d   = 1'b1;
                    pass_d  = 1'b0;
                end
            end
            ST_CHECK: begin
                pass_d  = (id_q == EXPECTED_ID) && (!CHECK_TS || (ts_q == EXPECTED_TS));
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign avm_read    = (state_q == ST_ID_CMD) || (state_q == ST_TS_CMD);
    assign avm_address = (state_q == ST_TS_CMD) ? ADDR_TS : ADDR_ID;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);
    assign pass        = pass_q;
    assign err_timeout = err_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Bench for soc_sysid_checker: three instances with different parameter sets
// share start/reset; each has its own scripted Avalon-MM slave. Expected
// results come from cycle-count arithmetic on the slave schedule.
module tb_soc_sysid_checker;

    localparam int NDUT = 3;
    localparam int WIN  = 40;
    localparam logic [31:0] P_ID    = 32'hACD51302;
    localparam logic [31:0] GOLD_TS = 32'h54943BE1;
    localparam logic [NDUT-1:0][31:0] P_TS  = {32'h0, 32'h0, GOLD_TS};
    localparam logic [NDUT-1:0]       P_CHK = 3'b011;
    localparam logic [NDUT-1:0][31:0] P_TO  = {32'd8, 32'd8, 32'd4};

    logic clock = 1'b0;
    logic reset;
    logic start;
    always #5 clock = ~clock;

    logic [NDUT-1:0] avm_address, avm_read, busy, done, pass, err_timeout;
    logic [31:0]     id_value [NDUT];
    logic [31:0]     ts_value [NDUT];

    // slave schedule: w = waitrequest cycles, l = readdatavalid latency (0 = never)
    int          w_id, l_id, w_ts, l_ts;
    logic [31:0] d_id, d_ts;

    int vectors     = 0;
    int miscompares = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic        wr;
        logic        rdv;
        logic [31:0] rdata;

        soc_sysid_checker #(
            .EXPECTED_ID (P_ID),
            .EXPECTED_TS (P_TS[g]),
            .CHECK_TS    (P_CHK[g]),
            .TIMEOUT     (int'(P_TO[g]))
        ) u_dut (
            .clock             (clock),
            .reset             (reset),
            .start             (start),
            .avm_address       (avm_address[g]),
            .avm_read          (avm_read[g]),
            .avm_waitrequest   (wr),
            .avm_readdata      (rdata),
            .avm_readdatavalid (rdv),
            .busy              (busy[g]),
            .done              (done[g]),
            .pass              (pass[g]),
            .err_timeout       (err_timeout[g]),
            .id_value          (id_value[g]),
            .ts_value          (ts_value[g])
        );

        initial begin : slave
            int stall;
            int pend;
            bit acc;
            bit acc_ts;
            stall  = 0;
            pend   = 0;
            acc    = 1'b0;
            acc_ts = 1'b0;
            wr     = 1'b0;
            rdv    = 1'b0;
            rdata  = '0;
            forever begin
                @(negedge clock);
                rdv   = 1'b0;
                rdata = $urandom;
                if (acc) begin
                    acc   = 1'b0;
                    stall = 0;
                    pend  = acc_ts ? l_ts : l_id;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        rdv   = 1'b1;
                        rdata = acc_ts ? d_ts : d_id;
                    end
                end
                if (avm_read[g] && !acc) begin
                    if (stall < (avm_address[g] ? w_ts : w_id)) begin
                        wr = 1'b1;
                        stall++;
                    end else begin
                        wr     = 1'b0;
                        acc    = 1'b1;
                        acc_ts = avm_address[g];
                    end
                end else begin
                    wr = 1'b0;
                    if (!avm_read[g]) stall = 0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // A read fails when the counter hits zero on a cycle without the awaited event.
    function automatic bit txn_fails(input int w, input int l, input int to);
        return (w > to) || (l == 0) || ((l >= 2) && (w + l > to));
    endfunction

    // Cycle (1-based within the read) on which the abort is decided.
    function automatic int abort_cyc(input int w, input int to);
        if (w > to) return to + 1;
        return (w + 2 > to + 1) ? (w + 2) : (to + 1);
    endfunction

    task automatic run_check(input string tag, input bit junk);
        int          ndone [NDUT];
        int          dcyc  [NDUT];
        logic [31:0] o_id  [NDUT];
        logic [31:0] o_ts  [NDUT];
        logic        o_pass[NDUT];
        logic        o_err [NDUT];
        logic        o_rd  [NDUT];
        logic        b1    [NDUT];
        int          e_cyc, to, len1;
        bit          e_pass, e_err;
        logic [31:0] e_id, e_ts;
        for (int i = 0; i < NDUT; i++) begin
            ndone[i] = 0; dcyc[i] = -1; o_id[i] = '0; o_ts[i] = '0;
            o_pass[i] = 1'b0; o_err[i] = 1'b0; o_rd[i] = 1'b1; b1[i] = 1'b0;
        end
        @(negedge clock);
        start = 1'b1;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clock);
            start = 1'b0;
            for (int i = 0; i < NDUT; i++) begin
                if (c == 1) b1[i] = busy[i];
                if (done[i]) begin
                    ndone[i]++;
                    if (ndone[i] == 1) begin
                        dcyc[i] = c; o_id[i] = id_value[i]; o_ts[i] = ts_value[i];
                        o_pass[i] = pass[i]; o_err[i] = err_timeout[i]; o_rd[i] = avm_read[i];
                    end
                end
            end
            if (junk && ((c == 3) || done[0])) start = 1'b1;
        end
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            to     = int'(P_TO[i]);
            len1   = w_id + 1 + l_id;
            e_id   = '0;
            e_ts   = '0;
            e_pass = 1'b0;
            e_err  = 1'b1;
            if (txn_fails(w_id, l_id, to)) begin
                e_cyc = abort_cyc(w_id, to) + 1;
            end else begin
                e_id = d_id;
                if (txn_fails(w_ts, l_ts, to)) begin
                    e_cyc = len1 + abort_cyc(w_ts, to) + 1;
                end else begin
                    e_ts   = d_ts;
                    e_err  = 1'b0;
                    e_cyc  = len1 + (w_ts + 1 + l_ts) + 2;
                    e_pass = (d_id == P_ID) && (!P_CHK[i] || (d_ts == P_TS[i]));
                end
            end
            check_eq($sformatf("%s.d%0d.ndone", tag, i), ndone[i], 1);
            check_eq($sformatf("%s.d%0d.done_cyc", tag, i), dcyc[i], e_cyc);
            check_eq($sformatf("%s.d%0d.pass", tag, i), {31'd0, o_pass[i]}, {31'd0, e_pass});
            check_eq($sformatf("%s.d%0d.err", tag, i), {31'd0, o_err[i]}, {31'd0, e_err});
            check_eq($sformatf("%s.d%0d.id", tag, i), o_id[i], e_id);
            check_eq($sformatf("%s.d%0d.ts", tag, i), o_ts[i], e_ts);
            check_eq($sformatf("%s.d%0d.read_at_done", tag, i), {31'd0, o_rd[i]}, 32'd0);
            check_eq($sformatf("%s.d%0d.busy_c1", tag, i), {31'd0, b1[i]}, 32'd1);
            check_eq($sformatf("%s.d%0d.busy_end", tag, i), {31'd0, busy[i]}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("%s.d%0d.busy", tag, i), {31'd0, busy[i]}, 32'd0);
            check_eq($sformatf("%s.d%0d.done", tag, i), {31'd0, done[i]}, 32'd0);
            check_eq($sformatf("%s.d%0d.pass", tag, i), {31'd0, pass[i]}, 32'd0);
            check_eq($sformatf("%s.d%0d.err", tag, i), {31'd0, err_timeout[i]}, 32'd0);
            check_eq($sformatf("%s.d%0d.read", tag, i), {31'd0, avm_read[i]}, 32'd0);
            check_eq($sformatf("%s.d%0d.addr", tag, i), {31'd0, avm_address[i]}, 32'd0);
            check_eq($sformatf("%s.d%0d.id", tag, i), id_value[i], 32'd0);
            check_eq($sformatf("%s.d%0d.ts", tag, i), ts_value[i], 32'd0);
        end
    endtask

    task automatic set_sched(input int wi, input int li, input int wt, input int lt,
                             input logic [31:0] di, input logic [31:0] dt);
        w_id = wi; l_id = li; w_ts = wt; l_ts = lt; d_id = di; d_ts = dt;
    endtask

    task automatic run_reset_test();
        int ndone [NDUT];
        for (int i = 0; i < NDUT; i++) ndone[i] = 0;
        set_sched(0, 5, 0, 1, P_ID, GOLD_TS);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        for (int i = 0; i < NDUT; i++)
            check_eq($sformatf("rst_mid.d%0d.busy_before", i), {31'd0, busy[i]}, 32'd1);
        reset = 1'b1;
        for (int c = 0; c < WIN; c++) begin
            @(negedge clock);
            reset = 1'b0;
            for (int i = 0; i < NDUT; i++) if (done[i]) ndone[i]++;
        end
        for (int i = 0; i < NDUT; i++)
            check_eq($sformatf("rst_mid.d%0d.ndone", i), ndone[i], 0);
        check_all_zero("rst_mid");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_sched(0, 1, 0, 1, P_ID, GOLD_TS);
        repeat (3) @(negedge clock);
        check_all_zero("reset_held");
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("reset_rel");

        // golden slave, zero wait: d0 and d2 pass, d1 fails on EXPECTED_TS=0
        run_check("golden", 1'b0);
        // waitrequest boundary around TIMEOUT=4
        set_sched(4, 1, 0, 1, P_ID, GOLD_TS);
        run_check("wr4", 1'b0);
        set_sched(5, 1, 0, 1, P_ID, GOLD_TS);
        run_check("wr5", 1'b0);
        set_sched(0, 1, 4, 1, P_ID, GOLD_TS);
        run_check("ts_wr4", 1'b0);
        set_sched(0, 4, 0, 5, P_ID, GOLD_TS);
        run_check("lat45", 1'b0);
        // timestamp read never answered
        set_sched(0, 1, 0, 0, P_ID, GOLD_TS);
        run_check("ts_lost", 1'b0);
        set_sched(9, 1, 0, 1, P_ID, GOLD_TS);
        run_check("wr9", 1'b0);

        run_reset_test();
        set_sched(0, 1, 0, 1, P_ID, GOLD_TS);
        run_check("post_rst", 1'b0);

        set_sched(1, 2, 2, 1, P_ID, GOLD_TS);
        run_check("junk_start", 1'b1);

        for (int n = 0; n < 30; n++) begin
            int          r;
            logic [31:0] di, dt;
            di = ($urandom_range(0, 3) != 0) ? P_ID : $urandom;
            r  = $urandom_range(0, 2);
            dt = (r == 0) ? GOLD_TS : ((r == 1) ? 32'h0 : $urandom);
            set_sched($urandom_range(0, 6),
                      ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6),
                      $urandom_range(0, 6),
                      ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6),
                      di, dt);
            run_check($sformatf("rnd%0d", n), $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/soc_sysid_checker.md
SOC_SYSID_CHECKER -- requirements
Module: soc_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000, is the system ID value the check requires.
REQ-002 Parameter EXPECTED_TS, default 32'h0000_0000, is the timestamp value the check requires.
REQ-003 Parameter CHECK_TS, default 1; 1 means the timestamp compare contributes to pass, 0 means it is ignored.
REQ-004 Parameter TIMEOUT, default 255, range 1..65535, is the maximum cycles per read transaction before abort.
REQ-005 Port clock, input, 1, is the single clock for all logic.
REQ-006 Port reset, input, 1, is the synchronous, active-high reset.
REQ-007 Port start, input, 1, is a one-cycle request to run a check; it is ignored unless the FSM is in IDLE.
REQ-008 Port avm_address, output, 1, is the word address: 0 = ID, 1 = timestamp.
REQ-009 Port avm_read, output, 1, is the Avalon-MM read command.
REQ-010 Port avm_waitrequest, input, 1, is the Avalon-MM command stall.
REQ-011 Port avm_readdata, input, 32, is the Avalon-MM read data.
REQ-012 Port avm_readdatavalid, input, 1, qualifies avm_readdata.
REQ-013 Port busy, output, 1, is high in every state except IDLE.
REQ-014 Port done, output, 1, is a one-cycle pulse at the end of each check.
REQ-015 Port pass, output, 1, is the result of the last check, held until the next start.
REQ-016 Port err_timeout, output, 1, is set when the last check aborted on timeout.
REQ-017 Port id_value, output, 32, is the captured ID word.
REQ-018 Port ts_value, output, 32, is the captured timestamp word.

Function
REQ-019 The FSM SHALL have the states IDLE, ID_CMD, ID_WAIT, TS_CMD, TS_WAIT, CHECK and FINISH.
REQ-020 In IDLE with start=1, the FSM SHALL move to ID_CMD, clear pass, err_timeout, id_value and ts_value, and load the timeout counter with TIMEOUT.
REQ-021 In ID_CMD, the block SHALL drive avm_read=1 and avm_address=0, hold both stable while avm_waitrequest=1, and move to ID_WAIT on the first cycle with avm_waitrequest=0.
REQ-022 In ID_WAIT, when avm_readdatavalid=1 the block SHALL capture avm_readdata into id_value, reload the timeout counter, and move to TS_CMD; avm_readdatavalid in the same cycle as command acceptance is not valid data.
REQ-023 TS_CMD and TS_WAIT SHALL behave as ID_CMD and ID_WAIT, except avm_address=1, capture goes to ts_value, and the next state is CHECK.
REQ-024 Only one read SHALL be outstanding at any time, and avm_read SHALL be 0 outside ID_CMD and TS_CMD.
REQ-025 avm_readdatavalid outside ID_WAIT and TS_WAIT SHALL be ignored.
REQ-026 The timeout counter SHALL decrement each cycle in the CMD and WAIT states.
REQ-027 When the counter is 0 and the awaited condition is absent, the FSM SHALL go to FINISH with err_timeout=1, pass=0, and avm_read deasserted in that same cycle.
REQ-028 When the awaited condition and the counter reaching 0 occur in the same cycle, the condition SHALL win and no timeout is raised.
REQ-029 With TIMEOUT=N, a stall of N cycles SHALL succeed and a stall of N+1 cycles SHALL time out.
REQ-030 In CHECK, the block SHALL set pass = (id_value==EXPECTED_ID) and (CHECK_TS==0 or ts_value==EXPECTED_TS), then go to FINISH.
REQ-031 FINISH SHALL assert done for exactly one cycle and return to IDLE; a start in that cycle SHALL be ignored.
REQ-032 The fastest check (no waitrequest, readdatavalid one cycle after acceptance) SHALL take 7 cycles from start to done.

Reset
REQ-033 Reset SHALL put the FSM in IDLE and set avm_read, avm_address, busy, done, pass, err_timeout, id_value, ts_value and the timeout counter to 0.
REQ-034 Reset asserted mid-transaction SHALL abandon it without a done pulse, and any later readdatavalid for that read SHALL be ignored.

Structure
REQ-035 The state encoding type and the address constants ADDR_ID=0 and ADDR_TS=1 SHALL live in the shared package soc_sysid_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the timeout counter is inline with width $clog2(TIMEOUT+1).

Verification
REQ-037 Slave returning 32'hACD51302 and 32'h54943BE1, parameters set to those values, zero wait -> done in cycle 7, pass=1, err_timeout=0.
REQ-038 Same slave with EXPECTED_TS=32'h0 and CHECK_TS=1 -> pass=0; with CHECK_TS=0 -> pass=1, ts_value=32'h54943BE1.
REQ-039 TIMEOUT=4 with waitrequest held for 4 cycles -> success; held for 5 cycles -> err_timeout=1, pass=0, avm_read low on the abort cycle, one done pulse.
REQ-040 readdatavalid never returned on the address-1 read, TIMEOUT=8 -> timeout, id_value captured, ts_value=0.
REQ-041 Reset pulsed during ID_WAIT, then a stray readdatavalid -> no done pulse, all outputs 0, and a new start runs a clean check.
REQ-042 start pulsed while busy and on the done cycle -> ignored, with exactly one done pulse per accepted start.
